layer_scatter: RTL and testbench

- Serial-to-parallel front end for the 32-input adder-tree reduction path.
- Accepts one time-multiplexed stream of per-channel partial sums, one word per cycle, channel 0 first.
- Regroups every N consecutive words into N parallel lanes. All lanes carry one common valid, which drives the tree's valid_in_1..valid_in_N together.
- Counts grouped pixel positions per D x D feature map and flags end of frame.

---
 rtl/layer_scatter.sv | 141 ++++++++++++++
 tb/tb_layer_scatter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/layer_scatter.sv
// layer_scatter: serial-to-parallel regrouper feeding the N-lane adder tree.
// Collects N consecutive channel words into one parallel group, pulses
// valid_out per group, counts groups per D x D frame and flags frame end.
// Optional build macro SCATTER_FLUSH_EN adds flush_in, which emits a
// zero-padded partial group.
module layer_scatter #(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32,
    parameter int N          = 32
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef SCATTER_FLUSH_EN
    input  logic                    flush_in,
`endif
    input  logic                    valid_in,
    input  logic                    sof_in,
    input  logic [DATA_WIDTH-1:0]   pxl_in,
    output logic [N*DATA_WIDTH-1:0] pxl_out,
    output logic                    valid_out,
    output logic                    frame_done,
    output logic                    align_err
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (D * D > 1) ? $clog2(D * D) : 1;
    // At N==1 the collect buffer is never written; keep one dummy entry.
    localparam int CN = (N > 1) ? N - 1 : 1;

    logic [LW-1:0]           lane_cnt_q, lane_cnt_d;
    logic [GW-1:0]           grp_cnt_q, grp_cnt_d;
    logic [DATA_WIDTH-1:0]   collect_q [CN];
    logic [DATA_WIDTH-1:0]   collect_d [CN];
    logic [N*DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic                    valid_out_q, valid_out_d;
    logic                    frame_done_q, frame_done_d;
    logic                    align_err_q, align_err_d;

    logic                    flush_w;
    logic [LW-1:0]           lane;
    logic [LW-1:0]           n_prev;
    logic [GW-1:0]           grp_base;
    logic                    emit;
    logic                    use_word;
    logic [DATA_WIDTH-1:0]   word;

`ifdef SCATTER_FLUSH_EN
    assign flush_w = flush_in;
`else
    assign flush_w = 1'b0;
`endif

    // Lane/group bookkeeping, collect writes and output group assembly.
    always_comb begin
        lane_cnt_d   = lane_cnt_q;
        grp_cnt_d    = grp_cnt_q;
        collect_d    = collect_q;
        pxl_out_d    = pxl_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        align_err_d  = 1'b0;
        emit         = 1'b0;
        use_word     = 1'b0;
        word         = '0;
        // A start-of-frame word always lands in lane 0 of group 0.
        lane         = sof_in ? '0 : lane_cnt_q;
        grp_base     = (valid_in && sof_in) ? '0 : grp_cnt_q;
        n_prev       = lane_cnt_q;

        if (valid_in) begin
            n_prev    = lane;
            use_word  = 1'b1;
            grp_cnt_d = grp_base;
            if (sof_in && (lane_cnt_q != '0 || grp_cnt_q != '0)) begin
                align_err_d = 1'b1;
            end
            if (lane == LW'(N - 1)) begin
                emit       = 1'b1;
                lane_cnt_d = '0;
            end else begin
                collect_d[lane] = pxl_in;
                lane_cnt_d      = lane + LW'(1);
                if (flush_w) begin
                    emit       = 1'b1;
                    lane_cnt_d = '0;
                end
            end
        end else if (flush_w && lane_cnt_q != '0) begin
            emit       = 1'b1;
            lane_cnt_d = '0;
        end

        if (emit) begin
            // Lanes below n_prev come from collect, the current word sits at
            // n_prev, anything above is padding (only reachable via flush).
            for (int k = 0; k < N; k++) begin
                word = '0;
                if (k < int'(n_prev)) begin
                    word = collect_q[(k < CN) ? k : 0];
                end else if (use_word && k == int'(n_prev)) begin
                    word = pxl_in;
                end
                pxl_out_d[k*DATA_WIDTH +: DATA_WIDTH] = word;
            end
            valid_out_d = 1'b1;
            if (grp_base == GW'(D * D - 1)) begin
                frame_done_d = 1'b1;
                grp_cnt_d    = '0;
            end else begin
                grp_cnt_d = grp_base + GW'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_cnt_q   <= '0;
            grp_cnt_q    <= '0;
            collect_q    <= '{default: '0};
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            grp_cnt_q    <= grp_cnt_d;
            collect_q    <= collect_d;
            pxl_out_q    <= pxl_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            align_err_q  <= align_err_d;
        end
    end

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign align_err  = align_err_q;

endmodule

// File: tb/tb_layer_scatter.sv
// Testbench for layer_scatter with N=32, D=4 (16 groups per frame).
// Build with SCATTER_FLUSH_EN defined to also exercise flush_in.
module tb_layer_scatter;

    localparam int D  = 4;
    localparam int DW = 32;
    localparam int N  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              valid_in = 1'b0;
    logic              sof_in = 1'b0;
    logic              flush_in = 1'b0;
    logic [DW-1:0]     pxl_in = '0;
    logic [N*DW-1:0]   pxl_out;
    logic              valid_out;
    logic              frame_done;
    logic              align_err;

    layer_scatter #(.D(D), .DATA_WIDTH(DW), .N(N)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SCATTER_FLUSH_EN
        .flush_in   (flush_in),
`endif
        .valid_in   (valid_in),
        .sof_in     (sof_in),
        .pxl_in     (pxl_in),
        .pxl_out    (pxl_out),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sof;
        logic [31:0] base;
        logic        gaps;
        logic        exp_fd;
        logic        chk_space;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] exp_l [N];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          vcount = 0;
    int          last_v = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_lanes(input string nm);
        int bad;
        bad = -1;
        checks++;
        for (int k = N - 1; k >= 0; k--) begin
            if (pxl_out[k*DW +: DW] !== exp_l[k]) bad = k;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: lane %0d got %0h expected %0h", nm, bad,
                     pxl_out[bad*DW +: DW], exp_l[bad]);
        end
    endtask

    // One clock: apply inputs, step past the edge, sample registered outputs.
    task automatic cycle(input logic v, input logic s, input logic [31:0] d);
        valid_in = v;
        sof_in   = s;
        pxl_in   = d;
        @(posedge clk);
        #1;
        cyc++;
        if (valid_out) begin
            vcount++;
            last_v = cyc;
        end
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    task automatic send_group(input logic s, input logic [31:0] base, input logic gaps,
                              output int early, output logic first_ae);
        early    = 0;
        first_ae = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) cycle(1'b0, 1'b0, 32'hDEAD);
            cycle(1'b1, s && (k == 0), base + 32'(k));
            if (k == 0) first_ae = align_err;
            if (k < N - 1 && valid_out) early++;
        end
    endtask

    initial begin
        int          early;
        logic        ae;
        int          prev_v;
        int          vsnap;

        vecs[0] = '{sof: 1'b1, base: 32'd1, gaps: 1'b0, exp_fd: 1'b0, chk_space: 1'b0};
        for (int i = 1; i < 16; i++)
            vecs[i] = '{sof: 1'b0, base: 32'h100 * 32'(i), gaps: 1'b0,
                        exp_fd: (i == 15), chk_space: 1'b1};
        vecs[16] = '{sof: 1'b1, base: 32'h5000, gaps: 1'b1, exp_fd: 1'b0, chk_space: 1'b0};

        // Reset state
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < N; k++) exp_l[k] = '0;
        chk_lanes("reset_pxl_out");
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_align_err", 32'(align_err), 32'd0);
        reset = 1'b0;

        // Table-driven groups: one full frame back-to-back, then a gapped group
        prev_v = 0;
        for (int i = 0; i < 17; i++) begin
            send_group(vecs[i].sof, vecs[i].base, vecs[i].gaps, early, ae);
            chk($sformatf("v%0d_no_early_valid", i), 32'(early), 32'd0);
            chk($sformatf("v%0d_first_align_err", i), 32'(ae), 32'd0);
            chk($sformatf("v%0d_valid_out", i), 32'(valid_out), 32'd1);
            chk($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].exp_fd));
            for (int k = 0; k < N; k++) exp_l[k] = vecs[i].base + 32'(k);
            chk_lanes($sformatf("v%0d_lanes", i));
            if (vecs[i].chk_space)
                chk($sformatf("v%0d_spacing", i), 32'(last_v - prev_v), 32'd32);
            prev_v = last_v;
        end

        // Hold after the gapped group: one-cycle pulse, data stable
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 32'hBEEF);
        chk("hold_valid_low", 32'(valid_out), 32'd0);
        chk("hold_frame_done_low", 32'(frame_done), 32'd0);
        chk_lanes("hold_lanes");

        // Misaligned sof: 10 words then sof with 0xAA
        vsnap = vcount;
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 32'h900 + 32'(k));
        cycle(1'b1, 1'b1, 32'hAA);
        chk("sof_align_err", 32'(align_err), 32'd1);
        chk("sof_no_valid_partial", 32'(vcount - vsnap), 32'd0);
        for (int k = 1; k < N; k++) begin
            cycle(1'b1, 1'b0, 32'hB00 + 32'(k));
            if (k == 1) chk("align_err_one_cycle", 32'(align_err), 32'd0);
        end
        chk("resync_valid_out", 32'(valid_out), 32'd1);
        chk("resync_count", 32'(vcount - vsnap), 32'd1);
        exp_l[0] = 32'hAA;
        for (int k = 1; k < N; k++) exp_l[k] = 32'hB00 + 32'(k);
        chk_lanes("resync_lanes");

        // Reset mid-group discards the partial group
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 32'h700 + 32'(k));
        reset = 1'b1;
        cycle(1'b1, 1'b0, 32'h777);
        cycle(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < N; k++) exp_l[k] = '0;
        chk_lanes("midreset_pxl_out");
        chk("midreset_valid_out", 32'(valid_out), 32'd0);
        reset = 1'b0;
        vsnap = vcount;
        for (int k = 0; k < N; k++) cycle(1'b1, 1'b0, 32'hC00 + 32'(k));
        chk("fresh_valid_out", 32'(valid_out), 32'd1);
        chk("fresh_count", 32'(vcount - vsnap), 32'd1);
        for (int k = 0; k < N; k++) exp_l[k] = 32'hC00 + 32'(k);
        chk_lanes("fresh_lanes");

`ifdef SCATTER_FLUSH_EN
        // Flush a 5-word partial group, then confirm lane counter restarted
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 32'd7 + 32'(k));
        flush_in = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        flush_in = 1'b0;
        chk("flush_valid_out", 32'(valid_out), 32'd1);
        for (int k = 0; k < N; k++) exp_l[k] = (k < 5) ? 32'd7 + 32'(k) : 32'd0;
        chk_lanes("flush_lanes");
        vsnap = vcount;
        for (int k = 0; k < N; k++) cycle(1'b1, 1'b0, 32'hD00 + 32'(k));
        chk("post_flush_valid_out", 32'(valid_out), 32'd1);
        chk("post_flush_count", 32'(vcount - vsnap), 32'd1);
        for (int k = 0; k < N; k++) exp_l[k] = 32'hD00 + 32'(k);
        chk_lanes("post_flush_lanes");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
